// File: rtl/escalonador_medidas_if.sv
// Signal bundle between the measurement scheduler and the robot's control,
// sensor and serial-TX datapath.
interface escalonador_medidas_if;
   logic        ligar;
   logic        parar;
   logic        pronto_med;
   logic [11:0] medida;
   logic        pronto_tx;
   logic [1:0]  sel_sensor;
   logic        medir;
   logic        partida_tx;
   logic [6:0]  dado_tx;
   logic [11:0] medida1;
   logic [11:0] medida2;
   logic [11:0] medida3;
   logic [2:0]  erro;
   logic        pronto;
   logic [3:0]  db_estado;

   modport master (
      input  ligar, parar, pronto_med, medida, pronto_tx,
      output sel_sensor, medir, partida_tx, dado_tx,
             medida1, medida2, medida3, erro, pronto, db_estado
   );

   modport slave (
      output ligar, parar, pronto_med, medida, pronto_tx,
      input  sel_sensor, medir, partida_tx, dado_tx,
             medida1, medida2, medida3, erro, pronto, db_estado
   );
endinterface

// File: rtl/escalonador_medidas.sv
// Round-robin scheduler: measures three ultrasonic sensors with one shared
// engine, then sends the results as the 12-character frame "ddd,ddd,ddd#".
module escalonador_medidas #(
   parameter int TIMEOUT   = 3000000,
   parameter int INTERVALO = 5000000
) (
   input logic                   clock,
   input logic                   reset,
   escalonador_medidas_if.master bus
);

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      PREPARA     = 4'd1,
      MEDE        = 4'd2,
      ESPERA_MED  = 4'd3,
      PROX_SENSOR = 4'd4,
      TRANSMITE   = 4'd5,
      ESPERA_TX   = 4'd6,
      FIM         = 4'd7,
      AGUARDA     = 4'd8
   } estado_t;

   localparam int CMAX = (TIMEOUT > INTERVALO) ? TIMEOUT : INTERVALO;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] ULTIMO_TO  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ULTIMO_INT = CW'(INTERVALO - 1);

   estado_t       estado_q, estado_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   medida_q [3];
   logic [11:0]   medida_d [3];
   logic [2:0]    erro_q, erro_d;
   logic [6:0]    dado_q, dado_d;
   logic          parar_q, parar_d;

   // Character k of the frame: sensor k/4, position k%4 (three digits then a separator).
   function automatic logic [6:0] caractere(input logic [3:0] k, input logic [11:0] m0,
                                            input logic [11:0] m1, input logic [11:0] m2);
      logic [11:0] m;
      logic [3:0]  nib;
      case (k[3:2])
         2'd0:    m = m0;
         2'd1:    m = m1;
         default: m = m2;
      endcase
      case (k[1:0])
         2'd0:    nib = m[11:8];
         2'd1:    nib = m[7:4];
         default: nib = m[3:0];
      endcase
      if (k[1:0] == 2'd3) return (k[3:2] == 2'd2) ? 7'h23 : 7'h2C;
      if (nib > 4'd9) return 7'h3F;
      return 7'h30 + {3'b000, nib};
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= INICIAL;
         idx_q    <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         erro_q   <= '0;
         dado_q   <= '0;
         parar_q  <= 1'b0;
         // NOTE: only three result words, so resetting them as flops is cheap and keeps outputs defined.
         for (int i = 0; i < 3; i++) medida_q[i] <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the values from before this edge.
         estado_q <= estado_d;
         idx_q    <= idx_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         erro_q   <= erro_d;
         dado_q   <= dado_d;
         parar_q  <= parar_d;
         medida_q <= medida_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:     if (bus.ligar) estado_d = PREPARA;
         PREPARA:     estado_d = MEDE;
         MEDE:        estado_d = ESPERA_MED;
         ESPERA_MED:  if (bus.pronto_med || cnt_q == ULTIMO_TO) estado_d = PROX_SENSOR;
         PROX_SENSOR: estado_d = (idx_q == 2'd2) ? TRANSMITE : MEDE;
         TRANSMITE:   estado_d = ESPERA_TX;
         ESPERA_TX:   if (bus.pronto_tx) estado_d = (k_q == 4'd11) ? FIM : TRANSMITE;
         FIM:         estado_d = parar_q ? INICIAL : AGUARDA;
         AGUARDA:     if (cnt_q == ULTIMO_INT) estado_d = PREPARA;
         default:     estado_d = INICIAL;
      endcase
   end

   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch behind.
      idx_d    = idx_q;
      k_d      = k_q;
      cnt_d    = '0;
      medida_d = medida_q;
      erro_d   = erro_q;
      dado_d   = dado_q;
      parar_d  = parar_q | bus.parar;

      case (estado_q)
         ESPERA_MED: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.pronto_med) begin
               medida_d[idx_q] = bus.medida;
               erro_d[idx_q]   = 1'b0;
            end else if (cnt_q == ULTIMO_TO) begin
               medida_d[idx_q] = 12'hFFF;
               erro_d[idx_q]   = 1'b1;
            end
         end
         AGUARDA:     cnt_d = cnt_q + 1'b1;
         PROX_SENSOR: if (idx_q != 2'd2) idx_d = idx_q + 2'd1; else k_d = '0;
         ESPERA_TX:   if (bus.pronto_tx && k_q != 4'd11) k_d = k_q + 4'd1;
         default:     ;
      endcase

      if (estado_d == PREPARA) idx_d = '0;
      if (estado_q == INICIAL || estado_d == INICIAL) parar_d = 1'b0;
      // Character is frozen on entry to TRANSMITE and held through ESPERA_TX.
      if (estado_d == TRANSMITE && estado_q != TRANSMITE)
         dado_d = caractere(k_d, medida_q[0], medida_q[1], medida_q[2]);
   end

   always_comb begin
      bus.medir      = (estado_q == MEDE);
      bus.partida_tx = (estado_q == TRANSMITE);
      bus.pronto     = (estado_q == FIM);
      bus.sel_sensor = idx_q;
      bus.dado_tx    = dado_q;
      bus.medida1    = medida_q[0];
      bus.medida2    = medida_q[1];
      bus.medida3    = medida_q[2];
      bus.erro       = erro_q;
      bus.db_estado  = estado_q;
   end

endmodule

// File: tb/tb_escalonador_medidas.sv
// Bench for escalonador_medidas: randomized engine/TX responders and a frame
// model built directly from the sensor values each round.
module tb_escalonador_medidas;
   localparam int TIMEOUT   = 100;
   localparam int INTERVALO = 20;

   logic clock;
   logic reset;
   escalonador_medidas_if bus ();

   escalonador_medidas #(.TIMEOUT(TIMEOUT), .INTERVALO(INTERVALO)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_checks = 0;
   int n_erros  = 0;
   int n_pronto = 0;
   int n_medir  = 0;
   int pronto_esp = 0;

   int          resp_delay [3];
   logic [11:0] resp_val   [3];
   bit          spur_tx    = 1'b0;
   bit          tx_chatter = 1'b0;
   bit          spur_med   = 1'b0;

   logic [6:0]  tx_log  [$];
   int          sel_log [$];
   logic [11:0] m_esp   [3];
   logic [2:0]  erro_esp;
   byte         quadro_esp [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_erros++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // Measurement engine: answers medir after resp_delay cycles (0 = never answers).
   initial begin : motor
      int s;
      int espera;
      logic [11:0] valor;
      espera = 0;
      valor  = '0;
      bus.pronto_med = 1'b0;
      bus.medida     = '0;
      forever begin
         @(negedge clock);
         bus.pronto_med = 1'b0;
         if (espera > 0) begin
            espera--;
            if (espera == 0) begin
               bus.pronto_med = 1'b1;
               bus.medida     = valor;
            end
         end
         if (bus.medir === 1'b1) begin
            s = int'(bus.sel_sensor);
            sel_log.push_back(s);
            n_medir++;
            if (s < 3 && resp_delay[s] > 0) begin
               espera = resp_delay[s];
               valor  = resp_val[s];
            end
         end else if (spur_med && bus.partida_tx === 1'b1) begin
            bus.pronto_med = 1'b1;
            bus.medida     = 12'h999;
         end
      end
   end

   // Serial transmitter: logs each started character and finishes it 2..5 cycles later.
   initial begin : transmissor
      int espera;
      int espuria;
      espera  = 0;
      espuria = 0;
      bus.pronto_tx = 1'b0;
      forever begin
         @(negedge clock);
         bus.pronto_tx = 1'b0;
         if (espera > 0) begin
            espera--;
            if (espera == 0) bus.pronto_tx = 1'b1;
         end
         if (espuria > 0) begin
            espuria--;
            if (espuria == 0) bus.pronto_tx = 1'b1;
         end
         if (bus.partida_tx === 1'b1) begin
            tx_log.push_back(bus.dado_tx);
            espera = int'($urandom_range(2, 5));
            if (tx_chatter) bus.pronto_tx = 1'b1;
         end
         if (spur_tx && bus.medir === 1'b1) espuria = 3;
      end
   end

   initial begin : monitor_pronto
      forever begin
         @(negedge clock);
         if (bus.pronto === 1'b1) n_pronto++;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_erros, n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic sortear();
      for (int s = 0; s < 3; s++) begin
         if ($urandom_range(0, 3) == 0) resp_val[s] = 12'($urandom);
         else resp_val[s] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         resp_delay[s] = int'($urandom_range(1, 40));
      end
   endtask

   // Expected latched values and frame text, from the values the engine will return.
   task automatic modelar();
      string digitos = "0123456789?";
      string separ   = ",,#";
      logic [3:0] nib;
      erro_esp = '0;
      quadro_esp.delete();
      for (int s = 0; s < 3; s++) begin
         if (resp_delay[s] == 0 || resp_delay[s] > TIMEOUT) begin
            m_esp[s]    = 12'hFFF;
            erro_esp[s] = 1'b1;
         end else begin
            m_esp[s] = resp_val[s];
         end
      end
      for (int s = 0; s < 3; s++) begin
         for (int d = 2; d >= 0; d--) begin
            nib = m_esp[s][4*d +: 4];
            quadro_esp.push_back(digitos[(nib < 4'd10) ? int'(nib) : 10]);
         end
         quadro_esp.push_back(separ[s]);
      end
   endtask

   task automatic esperar_pronto();
      int base = n_pronto;
      int c = 0;
      do begin
         tick();
         c++;
      end while (n_pronto == base && c < 3000);
      pronto_esp++;
      check("pronto_visto", n_pronto - base, 1);
   endtask

   task automatic esperar_medir(input int s);
      int c = 0;
      while (!(bus.medir === 1'b1 && int'(bus.sel_sensor) == s) && c < 500) begin
         tick();
         c++;
      end
      check($sformatf("medir_s%0d_visto", s), 32'(c < 500), 1);
   endtask

   task automatic verificar_rodada(input string nome);
      logic [31:0] got;
      check({nome, "_ncar"}, tx_log.size(), 12);
      for (int i = 0; i < 12; i++) begin
         got = (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF;
         check($sformatf("%s_car%0d", nome, i), got, 32'(quadro_esp[i]));
      end
      check({nome, "_nsel"}, sel_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         got = (i < sel_log.size()) ? 32'(sel_log[i]) : 32'hFFFF;
         check($sformatf("%s_sel%0d", nome, i), got, i);
      end
      check({nome, "_medida1"}, bus.medida1, m_esp[0]);
      check({nome, "_medida2"}, bus.medida2, m_esp[1]);
      check({nome, "_medida3"}, bus.medida3, m_esp[2]);
      check({nome, "_erro"}, bus.erro, erro_esp);
      tx_log.delete();
      sel_log.delete();
   endtask

   task automatic verificar_parado(input string nome);
      int base;
      repeat (3) tick();
      check({nome, "_estado"}, bus.db_estado, 0);
      base = n_medir;
      repeat (40) tick();
      check({nome, "_sem_medir"}, n_medir, base);
      check({nome, "_npronto"}, n_pronto, pronto_esp);
   endtask

   initial begin : principal
      int c;
      bus.ligar = 1'b0;
      bus.parar = 1'b0;
      reset     = 1'b1;
      for (int s = 0; s < 3; s++) begin
         resp_delay[s] = 0;
         resp_val[s]   = '0;
      end

      repeat (3) tick();
      check("rst_estado", bus.db_estado, 0);
      check("rst_ctrl", {bus.medir, bus.partida_tx, bus.pronto, bus.sel_sensor}, 0);
      check("rst_dado", bus.dado_tx, 0);
      check("rst_medidas", {bus.medida1, bus.medida2, bus.medida3}, 0);
      check("rst_erro", bus.erro, 0);
      reset = 1'b0;
      repeat (2) tick();

      // Normal round with fixed values, ligar latency, and a stray ligar mid-round.
      resp_val   = '{12'h025, 12'h130, 12'h007};
      resp_delay = '{10, 10, 10};
      modelar();
      bus.ligar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      check("lat_n1_estado", bus.db_estado, 1);
      check("lat_n1_medir", bus.medir, 0);
      tick();
      check("lat_n2_medir", bus.medir, 1);
      check("lat_n2_sel", bus.sel_sensor, 0);
      repeat (3) tick();
      bus.ligar = 1'b1;
      bus.parar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      bus.parar = 1'b0;
      esperar_pronto();
      verificar_rodada("normal");
      verificar_parado("normal_stop");
      check("normal_dado_mantido", bus.dado_tx, 7'h23);
      check("normal_retem_medida1", bus.medida1, 12'h025);

      // Sensor 1 never answers; spurious and coincident pronto_tx are active.
      spur_tx    = 1'b1;
      tx_chatter = 1'b1;
      resp_val   = '{12'h025, 12'h130, 12'h007};
      resp_delay = '{10, 0, 10};
      modelar();
      bus.ligar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      esperar_medir(1);
      repeat (100) tick();
      check("to_ultimo_ciclo_estado", bus.db_estado, 3);
      check("to_ultimo_ciclo_erro", bus.erro, 0);
      tick();
      check("to_estado", bus.db_estado, 4);
      check("to_erro", bus.erro, 3'b010);
      check("to_medida2", bus.medida2, 12'hFFF);
      bus.parar = 1'b1;
      tick();
      bus.parar = 1'b0;
      esperar_pronto();
      verificar_rodada("timeout");
      verificar_parado("timeout_stop");
      spur_tx    = 1'b0;
      tx_chatter = 1'b0;

      // Answer on the last timeout cycle wins; stray pronto_med during TX is ignored.
      spur_med = 1'b1;
      sortear();
      resp_val[1]   = 12'h456;
      resp_delay[1] = TIMEOUT;
      modelar();
      bus.ligar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      repeat (4) tick();
      bus.parar = 1'b1;
      tick();
      bus.parar = 1'b0;
      esperar_pronto();
      verificar_rodada("simult");
      verificar_parado("simult_stop");
      spur_med = 1'b0;

      // Continuous mode: two rounds, parar during sensor 1 of the second.
      sortear();
      modelar();
      bus.ligar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      esperar_pronto();
      verificar_rodada("cont1");
      sortear();
      modelar();
      c = 0;
      do begin
         tick();
         c++;
      end while (bus.medir !== 1'b1 && c < 60);
      check("cont_intervalo", c, INTERVALO + 2);
      check("cont_sel", bus.sel_sensor, 0);
      esperar_medir(1);
      bus.parar = 1'b1;
      tick();
      bus.parar = 1'b0;
      esperar_pronto();
      verificar_rodada("cont2");
      verificar_parado("cont_stop");

      // Reset during character k=5, then a fresh round.
      sortear();
      modelar();
      bus.ligar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      c = 0;
      while (tx_log.size() < 6 && c < 2000) begin
         tick();
         c++;
      end
      check("rst_meio_k5_visto", 32'(tx_log.size() >= 6), 1);
      reset = 1'b1;
      #1;
      check("rst_meio_estado", bus.db_estado, 0);
      check("rst_meio_ctrl", {bus.medir, bus.partida_tx, bus.pronto, bus.sel_sensor}, 0);
      check("rst_meio_dado", bus.dado_tx, 0);
      check("rst_meio_medidas", {bus.medida1, bus.medida2, bus.medida3, 9'd0, bus.erro}, 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (10) tick();
      check("rst_meio_sem_pronto", n_pronto, pronto_esp);
      tx_log.delete();
      sel_log.delete();
      sortear();
      modelar();
      bus.ligar = 1'b1;
      tick();
      bus.ligar = 1'b0;
      repeat (4) tick();
      bus.parar = 1'b1;
      tick();
      bus.parar = 1'b0;
      esperar_pronto();
      verificar_rodada("pos_rst");
      verificar_parado("pos_rst_stop");

      $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
      $finish;
   end

endmodule
